// File: rtl/icache_axi_read_responder_if.sv
// Read-address (AR) and read-data (R) channels of the ICache refill AXI4 link.
// The master drives AR and rready; the responder drives arready and R.
interface icache_axi_read_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  // Handshake: a transfer happens on a rising clk edge where valid && ready.
  // Once valid is high, it and its payload stay put until that edge.
  // The responder never waits for rready before raising rvalid.
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [ID_WIDTH-1:0]   arid;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ID_WIDTH-1:0]   rid;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rid, rresp, rlast
  );
endinterface

// File: rtl/icache_axi_read_responder.sv
// AXI4 read responder for ICache refills: one outstanding burst served from a backdoor-loaded memory.
// Define ICACHE_AXI_RAND_STALL_EN to insert LFSR-driven one-cycle bubbles between beats.
module icache_axi_read_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 2,
  localparam int IDX_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  icache_axi_read_responder_if.slave axi,
  input  logic                  init_we,
  input  logic [IDX_WIDTH-1:0]  init_addr,
  input  logic [DATA_WIDTH-1:0] init_data,
  output logic [1:0]            dbg_state
);

  localparam int OFF_BITS = $clog2(DATA_WIDTH / 8);
  localparam int LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  burst_err_q;
  logic [7:0]            beat_cnt;
  logic [LAT_W-1:0]      lat_cnt;

  logic                  arready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;

  logic [ADDR_WIDTH-1:0] align_mask;
  logic                  wrap_len_ok;
  logic                  ar_err;
  logic [ADDR_WIDTH-1:0] beat_bytes;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [ADDR_WIDTH-1:0] load_word;
  logic [7:0]            load_cnt;
  logic                  load_err;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_beat;
  logic                  r_fire;
  logic                  stall_now;

  assign axi.arready = arready_q & ~rst;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rid     = rid_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;
  assign dbg_state   = state;

  assign r_fire = rvalid_q & axi.rready;

`ifdef ICACHE_AXI_RAND_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall_now = (lfsr[1:0] == 2'b00);
`else
  assign stall_now = 1'b0;
`endif

  // Burst-wide error classification, evaluated on the AR request itself.
  always_comb begin
    align_mask  = (ADDR_WIDTH'(1) << axi.arsize) - ADDR_WIDTH'(1);
    wrap_len_ok = (axi.arlen == 8'd1) || (axi.arlen == 8'd3) ||
                  (axi.arlen == 8'd7) || (axi.arlen == 8'd15);
    ar_err      = (axi.arburst == 2'd3) ||
                  (axi.arsize > 3'(OFF_BITS)) ||
                  ((axi.arburst == 2'd2) &&
                   (!wrap_len_ok || ((axi.araddr & align_mask) != '0)));
  end

  // Address of the beat that gets loaded into the R registers this cycle.
  // While a beat is on the bus, the next load is the one after it.
  always_comb begin
    beat_bytes = ADDR_WIDTH'(1) << size_q;
    wrap_mask  = (ADDR_WIDTH'({1'b0, len_q} + 9'd1) << size_q) - ADDR_WIDTH'(1);
    case (burst_q)
      2'd1:    next_addr = addr_q + beat_bytes;
      2'd2:    next_addr = (addr_q & ~wrap_mask) | ((addr_q + beat_bytes) & wrap_mask);
      default: next_addr = addr_q;
    endcase

    if ((state == S_BURST) && rvalid_q) begin
      load_addr = next_addr;
      load_cnt  = beat_cnt - 8'd1;
    end else begin
      load_addr = addr_q;
      load_cnt  = beat_cnt;
    end

    load_word = load_addr >> OFF_BITS;
    load_err  = burst_err_q || (load_word >= ADDR_WIDTH'(MEM_DEPTH));
    if (load_err) begin
      load_data = '0;
    end else if (init_we && (init_addr == load_word[IDX_WIDTH-1:0])) begin
      load_data = init_data;
    end else begin
      load_data = mem[load_word[IDX_WIDTH-1:0]];
    end

    load_beat = ((state == S_WAIT) && (lat_cnt == '0)) ||
                ((state == S_BURST) && !rvalid_q) ||
                ((state == S_BURST) && r_fire && !rlast_q && !stall_now);
  end

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rid_q       <= '0;
      rresp_q     <= 2'd0;
      rlast_q     <= 1'b0;
      addr_q      <= '0;
      id_q        <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      burst_err_q <= 1'b0;
      beat_cnt    <= '0;
      lat_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (axi.arvalid && arready_q) begin
            addr_q      <= axi.araddr;
            id_q        <= axi.arid;
            len_q       <= axi.arlen;
            size_q      <= axi.arsize;
            burst_q     <= axi.arburst;
            burst_err_q <= ar_err;
            beat_cnt    <= axi.arlen;
            lat_cnt     <= LAT_W'(LATENCY - 1);
            arready_q   <= 1'b0;
            state       <= S_WAIT;
          end else begin
            arready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            state <= S_BURST;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        S_BURST: begin
          if (r_fire) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              state     <= S_IDLE;
            end else begin
              addr_q   <= next_addr;
              beat_cnt <= load_cnt;
              rvalid_q <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // A loaded beat overrides the bubble cleared above.
      if (load_beat) begin
        rvalid_q <= 1'b1;
        rdata_q  <= load_data;
        rid_q    <= id_q;
        rresp_q  <= load_err ? 2'd2 : 2'd0;
        rlast_q  <= (load_cnt == 8'd0);
      end
    end
  end

endmodule

// File: tb/tb_icache_axi_read_responder.sv
// Directed bench for icache_axi_read_responder: INCR/WRAP/FIXED bursts, stalls, errors, reset and backdoor writes.
module tb_icache_axi_read_responder;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_we;
  logic [9:0]  init_addr;
  logic [DW-1:0] init_data;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cap_data[16];
  logic [1:0]    cap_resp[16];
  logic          cap_last[16];
  logic [IW-1:0] cap_id[16];
  int            cap_cyc[16];
  int            got;

  icache_axi_read_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

  icache_axi_read_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (axi),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .dbg_state (dbg_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks (all entered and left on a negedge)
  task automatic backdoor_write(input int idx, input logic [DW-1:0] d);
    init_we   = 1'b1;
    init_addr = 10'(idx);
    init_data = d;
    @(negedge clk);
    init_we   = 1'b0;
  endtask

  task automatic issue_ar(input logic [AW-1:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [IW-1:0] id);
    bit ok;
    int n;
    ok = 0;
    n  = 0;
    axi.arvalid = 1'b1;
    axi.araddr  = a;
    axi.arlen   = len;
    axi.arsize  = size;
    axi.arburst = burst;
    axi.arid    = id;
    while (!ok && n < 20) begin
      if (axi.arready) ok = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    axi.arvalid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ar_handshake arready never seen got=0 exp=1");
    end
  endtask

  task automatic collect(input int nbeats);
    int cyc;
    cyc = 0;
    got = 0;
    axi.rready = 1'b1;
    while (got < nbeats && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (axi.rvalid && got < 16) begin
        cap_data[got] = axi.rdata;
        cap_resp[got] = axi.rresp;
        cap_last[got] = axi.rlast;
        cap_id[got]   = axi.rid;
        cap_cyc[got]  = cyc;
        got++;
      end
    end
    @(negedge clk);
    axi.rready = 1'b0;
    checks++;
    if (got != nbeats) begin
      failures++;
      $display("FAIL beat_count got=%0d exp=%0d", got, nbeats);
    end
  endtask

  task automatic wait_rvalid();
    int n;
    n = 0;
    while (!axi.rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!axi.rvalid) begin
      failures++;
      $display("FAIL rvalid_wait got=0 exp=1");
    end
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (axi.arready !== 1'b0) begin failures++; $display("FAIL rst_arready got=%b exp=0", axi.arready); end
    checks++; if (axi.rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b exp=0", axi.rvalid); end
    checks++; if (axi.rlast !== 1'b0) begin failures++; $display("FAIL rst_rlast got=%b exp=0", axi.rlast); end
    checks++; if (axi.rresp !== 2'd0) begin failures++; $display("FAIL rst_rresp got=%0d exp=0", axi.rresp); end
    checks++; if (axi.rid !== 4'd0) begin failures++; $display("FAIL rst_rid got=%0d exp=0", axi.rid); end
    checks++; if (axi.rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", axi.rdata); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (axi.arready !== 1'b1) begin failures++; $display("FAIL post_rst_arready got=%b exp=1", axi.arready); end
  endtask

  task automatic test_incr();
    issue_ar(32'h0, 8'd3, 3'd2, 2'd1, 4'd5);
    collect(4);
    checks++;
    if (cap_cyc[0] !== LAT) begin failures++; $display("FAIL incr_latency got=%0d exp=%0d", cap_cyc[0], LAT); end
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      checks++; if (cap_data[i] !== e) begin failures++; $display("FAIL incr_rdata[%0d] got=%h exp=%h", i, cap_data[i], e); end
      checks++; if (cap_id[i] !== 4'd5) begin failures++; $display("FAIL incr_rid[%0d] got=%0d exp=5", i, cap_id[i]); end
      checks++; if (cap_resp[i] !== 2'd0) begin failures++; $display("FAIL incr_rresp[%0d] got=%0d exp=0", i, cap_resp[i]); end
      checks++; if (cap_last[i] !== (i == 3)) begin failures++; $display("FAIL incr_rlast[%0d] got=%b exp=%b", i, cap_last[i], i == 3); end
      checks++; if (cap_cyc[i] !== LAT + i) begin failures++; $display("FAIL incr_beat_cycle[%0d] got=%0d exp=%0d", i, cap_cyc[i], LAT + i); end
    end
  endtask

  task automatic test_wrap();
    issue_ar(32'h8, 8'd3, 3'd2, 2'd2, 4'd6);
    collect(4);
    exp_q.push_back(32'h102);
    exp_q.push_back(32'h103);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h101);
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      checks++; if (cap_data[i] !== e) begin failures++; $display("FAIL wrap_rdata[%0d] got=%h exp=%h", i, cap_data[i], e); end
      checks++; if (cap_resp[i] !== 2'd0) begin failures++; $display("FAIL wrap_rresp[%0d] got=%0d exp=0", i, cap_resp[i]); end
      checks++; if (cap_last[i] !== (i == 3)) begin failures++; $display("FAIL wrap_rlast[%0d] got=%b exp=%b", i, cap_last[i], i == 3); end
    end
  endtask

  task automatic test_fixed();
    issue_ar(32'h4, 8'd2, 3'd2, 2'd0, 4'd1);
    collect(3);
    for (int i = 0; i < 3; i++) begin
      checks++; if (cap_data[i] !== 32'h101) begin failures++; $display("FAIL fixed_rdata[%0d] got=%h exp=00000101", i, cap_data[i]); end
      checks++; if (cap_last[i] !== (i == 2)) begin failures++; $display("FAIL fixed_rlast[%0d] got=%b exp=%b", i, cap_last[i], i == 2); end
    end
  endtask

  task automatic test_stall();
    logic [3:0]    pat;
    int            hs;
    int            c;
    bit            held;
    logic [DW-1:0] snap_data;
    logic          snap_last;
    pat  = 4'b1001;
    hs   = 0;
    c    = 0;
    held = 0;
    axi.rready = 1'b0;
    issue_ar(32'h0, 8'd3, 3'd2, 2'd1, 4'd3);
    wait_rvalid();
    while (hs < 4 && c < 40) begin
      if (held) begin
        checks++; if (axi.rdata !== snap_data) begin failures++; $display("FAIL stall_rdata_stable got=%h exp=%h", axi.rdata, snap_data); end
        checks++; if (axi.rlast !== snap_last) begin failures++; $display("FAIL stall_rlast_stable got=%b exp=%b", axi.rlast, snap_last); end
      end
      axi.rready = pat[3 - (c % 4)];
      held = 0;
      if (axi.rvalid && axi.rready) begin
        cap_data[hs] = axi.rdata;
        cap_last[hs] = axi.rlast;
        hs++;
      end else if (axi.rvalid) begin
        held      = 1;
        snap_data = axi.rdata;
        snap_last = axi.rlast;
      end
      @(negedge clk);
      c++;
    end
    axi.rready = 1'b1;
    checks++; if (hs !== 4) begin failures++; $display("FAIL stall_handshakes got=%0d exp=4", hs); end
    checks++; if (axi.arready !== 1'b1) begin failures++; $display("FAIL stall_arready_after got=%b exp=1", axi.arready); end
    checks++; if (axi.rvalid !== 1'b0) begin failures++; $display("FAIL stall_rvalid_after got=%b exp=0", axi.rvalid); end
    @(negedge clk);
    axi.rready = 1'b0;
    checks++; if (axi.rvalid !== 1'b0) begin failures++; $display("FAIL stall_extra_beat got=%b exp=0", axi.rvalid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_data[i] !== 32'h100 + 32'(i)) begin failures++; $display("FAIL stall_rdata[%0d] got=%h exp=%h", i, cap_data[i], 32'h100 + 32'(i)); end
      checks++; if (cap_last[i] !== (i == 3)) begin failures++; $display("FAIL stall_rlast[%0d] got=%b exp=%b", i, cap_last[i], i == 3); end
    end
  endtask

  task automatic test_boundary();
    issue_ar(32'hFFC, 8'd1, 3'd2, 2'd1, 4'd2);
    collect(2);
    checks++; if (cap_data[0] !== 32'hCAFE03FF) begin failures++; $display("FAIL bound_rdata0 got=%h exp=cafe03ff", cap_data[0]); end
    checks++; if (cap_resp[0] !== 2'd0) begin failures++; $display("FAIL bound_rresp0 got=%0d exp=0", cap_resp[0]); end
    checks++; if (cap_last[0] !== 1'b0) begin failures++; $display("FAIL bound_rlast0 got=%b exp=0", cap_last[0]); end
    checks++; if (cap_resp[1] !== 2'd2) begin failures++; $display("FAIL bound_rresp1 got=%0d exp=2", cap_resp[1]); end
    checks++; if (cap_data[1] !== 32'd0) begin failures++; $display("FAIL bound_rdata1 got=%h exp=0", cap_data[1]); end
    checks++; if (cap_last[1] !== 1'b1) begin failures++; $display("FAIL bound_rlast1 got=%b exp=1", cap_last[1]); end
  endtask

  task automatic test_bad_burst();
    issue_ar(32'h0, 8'd2, 3'd2, 2'd3, 4'd7);
    collect(3);
    for (int i = 0; i < 3; i++) begin
      checks++; if (cap_resp[i] !== 2'd2) begin failures++; $display("FAIL badburst_rresp[%0d] got=%0d exp=2", i, cap_resp[i]); end
      checks++; if (cap_data[i] !== 32'd0) begin failures++; $display("FAIL badburst_rdata[%0d] got=%h exp=0", i, cap_data[i]); end
      checks++; if (cap_last[i] !== (i == 2)) begin failures++; $display("FAIL badburst_rlast[%0d] got=%b exp=%b", i, cap_last[i], i == 2); end
    end
    issue_ar(32'h4, 8'd2, 3'd2, 2'd2, 4'd7);
    collect(3);
    checks++; if (cap_resp[0] !== 2'd2) begin failures++; $display("FAIL badwrap_len_rresp got=%0d exp=2", cap_resp[0]); end
  endtask

  task automatic test_reset_mid();
    axi.rready = 1'b1;
    issue_ar(32'h0, 8'd7, 3'd2, 2'd1, 4'd9);
    wait_rvalid();
    @(negedge clk);
    checks++; if (axi.rdata !== 32'h101) begin failures++; $display("FAIL rstmid_beat1 got=%h exp=00000101", axi.rdata); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (axi.rvalid !== 1'b0) begin failures++; $display("FAIL rstmid_rvalid got=%b exp=0", axi.rvalid); end
    checks++; if (axi.arready !== 1'b0) begin failures++; $display("FAIL rstmid_arready got=%b exp=0", axi.arready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (axi.arready !== 1'b1) begin failures++; $display("FAIL rstmid_arready_after got=%b exp=1", axi.arready); end
    checks++; if (axi.rvalid !== 1'b0) begin failures++; $display("FAIL rstmid_rvalid_after got=%b exp=0", axi.rvalid); end
    axi.rready = 1'b0;
  endtask

  task automatic test_backdoor();
    axi.rready = 1'b0;
    issue_ar(32'h0, 8'd1, 3'd2, 2'd1, 4'd4);
    wait_rvalid();
    @(negedge clk);
    checks++; if (axi.rdata !== 32'h100) begin failures++; $display("FAIL bd_beat0_held got=%h exp=00000100", axi.rdata); end
    // Write word 1 on the same edge that accepts beat 0 and loads beat 1.
    axi.rready = 1'b1;
    init_we    = 1'b1;
    init_addr  = 10'd1;
    init_data  = 32'hBEEF0001;
    @(negedge clk);
    init_we = 1'b0;
    checks++; if (axi.rvalid !== 1'b1) begin failures++; $display("FAIL bd_beat1_valid got=%b exp=1", axi.rvalid); end
    checks++; if (axi.rdata !== 32'hBEEF0001) begin failures++; $display("FAIL bd_beat1_rdata got=%h exp=beef0001", axi.rdata); end
    checks++; if (axi.rlast !== 1'b1) begin failures++; $display("FAIL bd_beat1_rlast got=%b exp=1", axi.rlast); end
    @(negedge clk);
    axi.rready = 1'b0;
    checks++; if (axi.rvalid !== 1'b0) begin failures++; $display("FAIL bd_done_rvalid got=%b exp=0", axi.rvalid); end
  endtask

  initial begin
    rst         = 1'b1;
    init_we     = 1'b0;
    init_addr   = '0;
    init_data   = '0;
    axi.arvalid = 1'b0;
    axi.araddr  = '0;
    axi.arid    = '0;
    axi.arlen   = '0;
    axi.arsize  = '0;
    axi.arburst = '0;
    axi.rready  = 1'b0;
    @(negedge clk);
    test_reset();
    for (int i = 0; i < 8; i++) backdoor_write(i, 32'h100 + 32'(i));
    backdoor_write(1023, 32'hCAFE03FF);
    test_incr();
    test_wrap();
    test_fixed();
    test_stall();
    test_boundary();
    test_bad_burst();
    test_reset_mid();
    test_backdoor();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache_axi_read_responder.md
Name: icache_axi_read_responder

Overview:
- AXI4 read-channel slave: the responder end of the instruction-cache refill AXI link.
- Accepts AR requests from the ICache master and returns bursts of R beats from an internal word-addressed memory.
- Used as the refill target in unit and subsystem simulation, and as a boot-ROM style responder on the ICache port.
- Supports FIXED/INCR/WRAP bursts, a configurable first-beat latency and error responses.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, R data width in bits (power of two, >= 32)
ID_WIDTH, 4, AXI ID width
MEM_DEPTH, 1024, number of DATA_WIDTH words in backing memory
LATENCY, 2, cycles from AR handshake to first rvalid (>= 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  ADDR_WIDTH  burst start byte address
arid  in  ID_WIDTH  transaction ID
arlen  in  8  beats minus one
arsize  in  3  log2 bytes per beat
arburst  in  2  0 FIXED, 1 INCR, 2 WRAP
rvalid  out  1  read data valid
rready  in  1  master ready
rdata  out  DATA_WIDTH  beat data
rid  out  ID_WIDTH  echoed arid
rresp  out  2  0 OKAY, 2 SLVERR
rlast  out  1  final beat
init_we  in  1  backdoor memory write (preload)
init_addr  in  $clog2(MEM_DEPTH)  backdoor word index
init_data  in  DATA_WIDTH  backdoor write data

Behaviour:
- Reset values: arready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0; FSM goes to IDLE. Memory contents are not reset.
- One outstanding transaction only. arready=1 only in IDLE and not during the cycle rst is high.
- FSM states:
  - IDLE: arvalid&arready latches addr/id/len/size/burst, loads the latency counter with LATENCY-1 and moves to WAIT. The beat counter is loaded with arlen.
  - WAIT: the counter decrements each cycle. When it reaches 0, go to BURST with rvalid=1 on the next cycle, so the first rvalid appears exactly LATENCY cycles after the AR handshake edge.
  - BURST: rvalid held high. rdata/rid/rresp/rlast stay stable while rvalid&!rready. On rvalid&rready: if rlast, return to IDLE (rvalid=0); otherwise advance the address and decrement the beat counter. rlast=1 exactly when the beat counter is 0.
- Address advance, with B = 1<<arsize:
  - FIXED: unchanged.
  - INCR: addr+B, truncated to ADDR_WIDTH.
  - WRAP: low bits inside a window of (arlen+1)*B bytes increment modulo the window size; upper bits are constant.
- Word index = addr >> log2(DATA_WIDTH/8). Read is combinational from the array into a registered rdata, updated when a beat is loaded.
- SLVERR (rresp=2, rdata=0) applies to all beats of a burst when any of these hold:
  - arburst==3.
  - arsize > log2(DATA_WIDTH/8).
  - WRAP with arlen not in {1,3,7,15}.
  - WRAP with start address not B-aligned.
- SLVERR also applies per beat when the beat's word index >= MEM_DEPTH. A SLVERR burst still returns arlen+1 beats with a correct rlast.
- Backdoor write: init_we writes the array in the same cycle and is allowed in any state. If it hits the word being loaded for the next beat, the new data is returned (write-first).
- Reset mid-burst: all outstanding beats are dropped; no rvalid the cycle after rst.
- Sub-word arsize: the full DATA_WIDTH word is returned; the master selects lanes.

Optional Feature:
- ICACHE_AXI_RAND_STALL_EN: when defined, a 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle. In BURST, before presenting a new beat, rvalid is withheld for one cycle whenever lfsr[1:0]==0. Once asserted, rvalid is never dropped before the handshake.
- Without the macro: back-to-back beats with no bubbles whenever rready=1.

Test Plan:
- Preload words 0..7 = 32'h100+i. AR addr=0x0, len=3, size=2, INCR, id=5, rready=1 → rvalid 2 cycles after the AR handshake. rdata 0x100..0x103 on consecutive cycles, rid=5, rresp=0, rlast on the 4th beat only.
- AR addr=0x8, len=3, size=2, WRAP → beats from words 2,3,0,1 = 0x102,0x103,0x100,0x101.
- Same INCR burst with rready toggling 1,0,0,1 → rdata/rlast held stable while stalled. Exactly 4 handshakes, then arready=1 the next cycle.
- AR addr=0xFFC (MEM_DEPTH=1024), len=1, INCR → beat0 OKAY with word 1023. Beat1 rresp=2, rdata=0, rlast=1.
- AR burst=3, len=2 → 3 beats, all rresp=2. Then assert rst during beat 2 of a new len=7 burst → next cycle rvalid=0 and arready=0. One cycle after rst deasserts, arready=1.
- AXI and backdoor writes interleaved: init_we to word 1 while beat 0 of an INCR burst from word 0 is stalled → beat 1 returns the new value.
